// File: rtl/wb_csr_bridge.sv
// Wishbone-slave to CSR-bus bridge.
// Each Wishbone access becomes one CSR access, either a single-cycle write
// strobe or a read that waits READ_WAIT cycles before sampling csr_di.
// Every output comes straight from a flop.
module wb_csr_bridge #(
  parameter int READ_WAIT = 1
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  output logic        wb_ack_o,
  output logic [13:0] csr_a,
  output logic        csr_we,
  output logic [31:0] csr_do,
  input  logic [31:0] csr_di
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, ACK} state_t;

  // Final value of the read counter: csr_di is sampled when the count reaches it.
  localparam logic [2:0] WAIT_LAST = 3'(READ_WAIT);

  state_t      state_reg, state_next;
  logic [2:0]  cnt_reg, cnt_next;
  logic [13:0] csr_a_reg, csr_a_next;
  logic [31:0] csr_do_reg, csr_do_next;
  logic        csr_we_reg, csr_we_next;
  logic        ack_reg, ack_next;
  logic [31:0] dat_o_reg, dat_o_next;

  // Byte-lane bits and upper address bits do not take part in CSR decoding.
  logic unused_adr;
  assign unused_adr = ^{wb_adr_i[31:16], wb_adr_i[1:0]};

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      csr_a_reg  <= '0;
      csr_do_reg <= '0;
      csr_we_reg <= 1'b0;
      ack_reg    <= 1'b0;
      dat_o_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      csr_a_reg  <= csr_a_next;
      csr_do_reg <= csr_do_next;
      csr_we_reg <= csr_we_next;
      ack_reg    <= ack_next;
      dat_o_reg  <= dat_o_next;
    end
  end

  // Next-state and next-output logic; strobes default low, data holds.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    csr_a_next  = csr_a_reg;
    csr_do_next = csr_do_reg;
    dat_o_next  = dat_o_reg;
    csr_we_next = 1'b0;
    ack_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          csr_a_next  = wb_adr_i[15:2];
          csr_do_next = wb_dat_i;
          cnt_next    = '0;
          if (wb_we_i) begin
            state_next  = WRITE;
            csr_we_next = 1'b1;
          end else begin
            state_next = READ;
          end
        end
      end
      WRITE: begin
        // The strobe has already been issued; only the ack can be dropped.
        if (wb_cyc_i) begin
          state_next = ACK;
          ack_next   = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      READ: begin
        if (!wb_cyc_i) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == WAIT_LAST) begin
          dat_o_next = csr_di;
          ack_next   = 1'b1;
          cnt_next   = '0;
          state_next = ACK;
        end else begin
          cnt_next = cnt_reg + 3'd1;
        end
      end
      ACK: begin
        // No accept here: the master still sees ack this cycle.
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign csr_a    = csr_a_reg;
  assign csr_do   = csr_do_reg;
  assign csr_we   = csr_we_reg;
  assign wb_ack_o = ack_reg;
  assign wb_dat_o = dat_o_reg;

endmodule
